data_memory_controller: RTL and testbench
=========================================

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 SHALL have parameter WORDS, default 1024, meaning the storage depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default `MEMORY_DEPTH (32), meaning the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port memory_read_enable, input, 1 bit: read request.
REQ-006 SHALL have port memory_read_address, input, ADDR_W bits: read byte address.
REQ-007 SHALL have port memory_read_width, input, 2 bits: 1 = byte, 2 = half, 3 = word, 0 = no read.
REQ-008 SHALL have port memory_read_data, output, 32 bits: read bytes, right-aligned and zero-extended.
REQ-009 SHALL have port memory_read_valid, output, 1 bit: memory_read_data valid, one-cycle pulse.
REQ-010 SHALL have port memory_write_enable, input, 1 bit: write request.
REQ-011 SHALL have port memory_write_width, input, 2 bits: encoding as REQ-007, with 0 = no write.
REQ-012 SHALL have port memory_write_address, input, ADDR_W bits: write byte address.
REQ-013 SHALL have port memory_write_data, input, 32 bits: write data, right-aligned (low bytes used).
REQ-014 SHALL have port memory_busy, output, 1 bit: requests not sampled; the requester holds all inputs stable.

Function
REQ-015 SHALL sample requests only on a rising edge where memory_busy=0; a request with width 0 is ignored.
REQ-016 SHALL store WORDS x 4 byte lanes, with word index = address[log2(WORDS)+1:2] and upper bits ignored (wrap-around).
REQ-017 SHALL treat the access as split when (address[1:0] + bytes) > 4, i.e. it crosses a word boundary; the second part uses index+1, wrapping from WORDS-1 to 0.
REQ-018 SHALL use states IDLE, WR_HI, RD_HI, RD_PEND, with memory_busy = (state != IDLE).
REQ-019 SHALL, for an aligned/non-split write in IDLE, commit the selected lanes at the accepting edge and stay in IDLE.
REQ-020 SHALL, for a split write, commit the low part at the accepting edge, go to WR_HI, commit the remaining bytes at the next edge, then go to IDLE or RD_PEND.
REQ-021 SHALL, for a non-split read alone, pulse memory_read_valid in the cycle after acceptance (1-cycle latency).
REQ-022 SHALL, for a split read, fetch the low word, go to RD_HI, fetch the high word, and pulse valid after RD_HI (2-cycle latency).
REQ-023 SHALL, on simultaneous read and write acceptance, commit the write first (including WR_HI if split), then perform the read from RD_PEND, so the read returns post-write data.
REQ-024 SHALL hold memory_read_data between valid pulses.
REQ-025 SHALL reassemble split-read bytes in address order, low address in bits [7:0] (little-endian).

Reset
REQ-026 SHALL, on rst, set the state to IDLE, memory_read_data to 0, memory_read_valid to 0, and memory_busy to 0, and discard any in-flight split or pending operation.
REQ-027 SHALL NOT reset storage contents, and SHALL perform no write at an edge where rst is high.

Structure
REQ-028 SHALL place the state enum, the width codes (WIDTH_NONE/BYTE/HALF/WORD), and the byte-count function in shared package data_memory_pkg.
REQ-029 SHALL use one sub-module, data_memory_lane_align: a combinational block mapping offset + width + data to a 4-bit lane mask and shifted data for the low and high parts.

Verification
REQ-030 SHALL cover: write word 0xDEADBEEF at 0x10, then read word 0x10 -> valid 1 cycle later, data 0xDEADBEEF, busy stays 0.
REQ-031 SHALL cover: write byte 0xAA at 0x13, then read word 0x10 -> 0xAAADBEEF; read half 0x12 -> 0x0000AAAD.
REQ-032 SHALL cover: split write half 0x1234 at 0x17 -> busy=1 for 1 cycle; read byte 0x17 -> 0x34, read byte 0x18 -> 0x12; split read half 0x17 -> 0x1234 after 2 cycles.
REQ-033 SHALL cover: simultaneous write word 0x55667788 at 0x20 and read word 0x20 -> busy for 1 cycle, valid 2 cycles after acceptance, data 0x55667788.
REQ-034 SHALL cover: word write to index WORDS-1 with offset 2 -> high half lands in word 0; a read of word 0 confirms it.
REQ-035 SHALL cover: assert rst during RD_HI -> no valid pulse, busy=0 and data=0 next cycle, and a following aligned read succeeds.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types for the data memory controller: FSM states, access width codes, byte counts.
// No logic of its own; imported by the controller and its lane aligner.
// Width codes double as "no request" when zero.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HI   = 2'd1,
        RD_HI   = 2'd2,
        RD_PEND = 2'd3
    } state_t;

    localparam logic [1:0] WIDTH_NONE = 2'd0;
    localparam logic [1:0] WIDTH_BYTE = 2'd1;
    localparam logic [1:0] WIDTH_HALF = 2'd2;
    localparam logic [1:0] WIDTH_WORD = 2'd3;

    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_lane_align.sv
// Maps byte offset + width + right-aligned data onto lane masks and lane data for two words.
// Purely combinational, zero latency; no flow control.
// The high part is non-empty only when the access crosses a word boundary.
module data_memory_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic [31:0] data,
    output logic [3:0]  lo_mask,
    output logic [3:0]  hi_mask,
    output logic [31:0] lo_data,
    output logic [31:0] hi_data,
    output logic        split
);

    logic [7:0]  base_mask;
    logic [7:0]  shifted_mask;
    logic [63:0] shifted_data;

    always_comb begin
        case (width_bytes(width))
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            3'd4:    base_mask = 8'h0F;
            default: base_mask = 8'h00;
        endcase
        shifted_mask = base_mask << offset;
        shifted_data = {32'h0, data} << {offset, 3'b000};
        lo_mask      = shifted_mask[3:0];
        hi_mask      = shifted_mask[7:4];
        lo_data      = shifted_data[31:0];
        hi_data      = shifted_data[63:32];
        split        = |shifted_mask[7:4];
    end

endmodule

// File: rtl/data_memory_controller.sv
// Byte-addressed data memory with byte/half/word access and unaligned (word-crossing) support.
// Latency: read 1 cycle, split read 2, read behind a write 2 (3 if the write splits).
// Backpressure: memory_busy high while a split or pending op runs; requests are not sampled then.
module data_memory_controller
    import data_memory_pkg::*;
#(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memory_read_enable,
    input  logic [ADDR_W-1:0] memory_read_address,
    input  logic [1:0]        memory_read_width,
    output logic [31:0]       memory_read_data,
    output logic              memory_read_valid,
    input  logic              memory_write_enable,
    input  logic [1:0]        memory_write_width,
    input  logic [ADDR_W-1:0] memory_write_address,
    input  logic [31:0]       memory_write_data,
    output logic              memory_busy
);

    localparam int IDX_W = $clog2(WORDS);
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W+1:0] baddr_t;

    logic [31:0] mem [WORDS];

    state_t      state_q, state_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;
    baddr_t      rd_addr_q, rd_addr_d;
    baddr_t      wr_addr_q, wr_addr_d;
    logic [1:0]  rd_width_q, rd_width_d;
    logic [1:0]  wr_width_q, wr_width_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] rd_lo_q, rd_lo_d;
    logic        rd_pend_q, rd_pend_d;

    logic        idle, rd_req, wr_req, do_read;
    baddr_t      rd_addr_sel, wr_addr_sel;
    logic [1:0]  rd_width_sel, wr_width_sel;
    logic [31:0] wr_data_sel;
    idx_t        rd_idx, rd_idx_hi, wr_idx, wr_idx_hi;
    logic [2:0]  rd_bytes;
    logic        rd_split;
    logic [31:0] rd_lo_word, rd_hi_word;
    logic [3:0]  wr_lo_mask, wr_hi_mask;
    logic [31:0] wr_lo_data, wr_hi_data;
    logic        wr_split;

    logic        mem_we;
    idx_t        mem_widx;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdat;

    // Address bits above the storage index only alias (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memory_read_address[ADDR_W-1:IDX_W+2],
                                memory_write_address[ADDR_W-1:IDX_W+2]};

    function automatic logic [31:0] assemble(input logic [63:0] pair, input logic [1:0] off,
                                             input logic [2:0] nbytes);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (nbytes)
            3'd1:    return {24'h0, sh[7:0]};
            3'd2:    return {16'h0, sh[15:0]};
            default: return sh[31:0];
        endcase
    endfunction

    assign idle   = (state_q == IDLE);
    assign rd_req = memory_read_enable && (memory_read_width != WIDTH_NONE);
    assign wr_req = memory_write_enable && (memory_write_width != WIDTH_NONE);

    // In IDLE act on the live request; otherwise on what was captured at acceptance.
    assign rd_addr_sel  = idle ? memory_read_address[IDX_W+1:0] : rd_addr_q;
    assign rd_width_sel = idle ? memory_read_width : rd_width_q;
    assign wr_addr_sel  = idle ? memory_write_address[IDX_W+1:0] : wr_addr_q;
    assign wr_width_sel = idle ? memory_write_width : wr_width_q;
    assign wr_data_sel  = idle ? memory_write_data : wr_data_q;

    assign rd_idx    = rd_addr_sel[IDX_W+1:2];
    assign rd_idx_hi = (rd_idx == idx_t'(WORDS - 1)) ? '0 : rd_idx + 1'b1;
    assign wr_idx    = wr_addr_sel[IDX_W+1:2];
    assign wr_idx_hi = (wr_idx == idx_t'(WORDS - 1)) ? '0 : wr_idx + 1'b1;

    assign rd_bytes   = width_bytes(rd_width_sel);
    assign rd_split   = ({1'b0, rd_addr_sel[1:0]} + rd_bytes) > 3'd4;
    assign rd_lo_word = mem[rd_idx];
    assign rd_hi_word = mem[rd_idx_hi];

    data_memory_lane_align u_wr_align (
        .offset  (wr_addr_sel[1:0]),
        .width   (wr_width_sel),
        .data    (wr_data_sel),
        .lo_mask (wr_lo_mask),
        .hi_mask (wr_hi_mask),
        .lo_data (wr_lo_data),
        .hi_data (wr_hi_data),
        .split   (wr_split)
    );

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_vld_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_width_d = rd_width_q;
        wr_addr_d  = wr_addr_q;
        wr_width_d = wr_width_q;
        wr_data_d  = wr_data_q;
        rd_lo_d    = rd_lo_q;
        rd_pend_d  = rd_pend_q;
        mem_we     = 1'b0;
        mem_widx   = wr_idx;
        mem_wmask  = wr_lo_mask;
        mem_wdat   = wr_lo_data;
        do_read    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    mem_we     = 1'b1;
                    wr_addr_d  = wr_addr_sel;
                    wr_width_d = memory_write_width;
                    wr_data_d  = memory_write_data;
                    rd_addr_d  = rd_addr_sel;
                    rd_width_d = memory_read_width;
                    rd_pend_d  = rd_req;
                    if (wr_split) begin
                        state_d = WR_HI;
                    end else if (rd_req) begin
                        state_d = RD_PEND;
                    end
                end else if (rd_req) begin
                    rd_addr_d  = rd_addr_sel;
                    rd_width_d = memory_read_width;
                    do_read    = 1'b1;
                end
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_widx  = wr_idx_hi;
                mem_wmask = wr_hi_mask;
                mem_wdat  = wr_hi_data;
                rd_pend_d = 1'b0;
                state_d   = rd_pend_q ? RD_PEND : IDLE;
            end
            RD_PEND: begin
                do_read = 1'b1;
            end
            RD_HI: begin
                rd_data_d = assemble({rd_hi_word, rd_lo_q}, rd_addr_sel[1:0], rd_bytes);
                rd_vld_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_read) begin
            if (rd_split) begin
                rd_lo_d = rd_lo_word;
                state_d = RD_HI;
            end else begin
                rd_data_d = assemble({32'h0, rd_lo_word}, rd_addr_sel[1:0], rd_bytes);
                rd_vld_d  = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_width_q <= WIDTH_NONE;
            wr_addr_q  <= '0;
            wr_width_q <= WIDTH_NONE;
            wr_data_q  <= '0;
            rd_lo_q    <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            rd_width_q <= rd_width_d;
            wr_addr_q  <= wr_addr_d;
            wr_width_q <= wr_width_d;
            wr_data_q  <= wr_data_d;
            rd_lo_q    <= rd_lo_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Storage is never cleared; writes are only suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (mem_wmask[lane]) begin
                    mem[mem_widx][lane*8 +: 8] <= mem_wdat[lane*8 +: 8];
                end
            end
        end
    end

    assign memory_busy       = !idle;
    assign memory_read_data  = rd_data_q;
    assign memory_read_valid = rd_vld_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: aligned, byte/half, split, simultaneous, wrap and reset cases.
module tb_data_memory_controller;

    logic        clk;
    logic        rst;
    logic        memory_read_enable;
    logic [31:0] memory_read_address;
    logic [1:0]  memory_read_width;
    logic [31:0] memory_read_data;
    logic        memory_read_valid;
    logic        memory_write_enable;
    logic [1:0]  memory_write_width;
    logic [31:0] memory_write_address;
    logic [31:0] memory_write_data;
    logic        memory_busy;

    int total = 0;
    int bad   = 0;

    data_memory_controller #(.WORDS(1024), .ADDR_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .memory_read_enable   (memory_read_enable),
        .memory_read_address  (memory_read_address),
        .memory_read_width    (memory_read_width),
        .memory_read_data     (memory_read_data),
        .memory_read_valid    (memory_read_valid),
        .memory_write_enable  (memory_write_enable),
        .memory_write_width   (memory_write_width),
        .memory_write_address (memory_write_address),
        .memory_write_data    (memory_write_data),
        .memory_busy          (memory_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request, let one rising edge accept it, return 1ns after that edge.
    task automatic issue(input logic re, input logic [31:0] ra, input logic [1:0] rw,
                         input logic we, input logic [31:0] wa, input logic [1:0] ww,
                         input logic [31:0] wd);
        memory_read_enable   = re;
        memory_read_address  = ra;
        memory_read_width    = rw;
        memory_write_enable  = we;
        memory_write_address = wa;
        memory_write_width   = ww;
        memory_write_data    = wd;
        @(posedge clk); #1;
        memory_read_enable   = 1'b0;
        memory_read_width    = 2'd0;
        memory_write_enable  = 1'b0;
        memory_write_width   = 2'd0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", memory_busy); end
        total++; if (memory_read_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", memory_read_valid); end
        total++; if (memory_read_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 00000000", memory_read_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word();
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'h10, 2'd3, 32'hDEADBEEF);
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL word_wr_busy: got %b want 0", memory_busy); end
        issue(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_valid !== 1'b1) begin bad++; $display("FAIL word_rd_valid: got %b want 1", memory_read_valid); end
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data: got %h want deadbeef", memory_read_data); end
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL word_rd_busy: got %b want 0", memory_busy); end
        step();
        total++; if (memory_read_valid !== 1'b0) begin bad++; $display("FAIL word_pulse_end: got %b want 0", memory_read_valid); end
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL word_hold: got %h want deadbeef", memory_read_data); end
    endtask

    task automatic test_byte_half();
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'h13, 2'd1, 32'h123456AA);
        issue(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'hAAADBEEF || memory_read_valid !== 1'b1) begin bad++; $display("FAIL byte_merge: got %h/%b want aaadbeef/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'h12, 2'd2, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h0000AAAD || memory_read_valid !== 1'b1) begin bad++; $display("FAIL half_rd: got %h/%b want 0000aaad/1", memory_read_data, memory_read_valid); end
    endtask

    task automatic test_split();
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'h17, 2'd2, 32'hABCD1234);
        total++; if (memory_busy !== 1'b1) begin bad++; $display("FAIL split_wr_busy: got %b want 1", memory_busy); end
        step();
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL split_wr_done: got %b want 0", memory_busy); end
        issue(1'b1, 32'h17, 2'd1, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h34 || memory_read_valid !== 1'b1) begin bad++; $display("FAIL split_lo_byte: got %h/%b want 00000034/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'h18, 2'd1, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h12 || memory_read_valid !== 1'b1) begin bad++; $display("FAIL split_hi_byte: got %h/%b want 00000012/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'h17, 2'd2, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_valid !== 1'b0 || memory_busy !== 1'b1) begin bad++; $display("FAIL split_rd_wait: got valid=%b busy=%b want 0/1", memory_read_valid, memory_busy); end
        step();
        total++; if (memory_read_data !== 32'h1234 || memory_read_valid !== 1'b1) begin bad++; $display("FAIL split_rd_data: got %h/%b want 00001234/1", memory_read_data, memory_read_valid); end
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL split_rd_busy: got %b want 0", memory_busy); end
    endtask

    task automatic test_simultaneous();
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'h20, 2'd3, 32'h11111111);
        issue(1'b1, 32'h20, 2'd3, 1'b1, 32'h20, 2'd3, 32'h55667788);
        total++; if (memory_busy !== 1'b1 || memory_read_valid !== 1'b0) begin bad++; $display("FAIL simul_pend: got busy=%b valid=%b want 1/0", memory_busy, memory_read_valid); end
        step();
        total++; if (memory_busy !== 1'b0) begin bad++; $display("FAIL simul_busy_end: got %b want 0", memory_busy); end
        total++; if (memory_read_data !== 32'h55667788 || memory_read_valid !== 1'b1) begin bad++; $display("FAIL simul_data: got %h/%b want 55667788/1", memory_read_data, memory_read_valid); end
        // Split write racing a read of the word it partially overwrites.
        issue(1'b1, 32'h20, 2'd3, 1'b1, 32'h22, 2'd3, 32'hA1B2C3D4);
        total++; if (memory_busy !== 1'b1) begin bad++; $display("FAIL simul_split_wrhi: got %b want 1", memory_busy); end
        step();
        total++; if (memory_busy !== 1'b1 || memory_read_valid !== 1'b0) begin bad++; $display("FAIL simul_split_pend: got busy=%b valid=%b want 1/0", memory_busy, memory_read_valid); end
        step();
        total++; if (memory_read_data !== 32'hC3D47788 || memory_read_valid !== 1'b1) begin bad++; $display("FAIL simul_split_data: got %h/%b want c3d47788/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'h24, 2'd2, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h0000A1B2) begin bad++; $display("FAIL simul_split_hi: got %h want 0000a1b2", memory_read_data); end
    endtask

    task automatic test_wrap();
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 2'd3, 32'h00000000);
        issue(1'b0, 32'h0, 2'd0, 1'b1, 32'hFFE, 2'd3, 32'hCAFEF00D);
        total++; if (memory_busy !== 1'b1) begin bad++; $display("FAIL wrap_wr_busy: got %b want 1", memory_busy); end
        step();
        issue(1'b1, 32'h0, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h0000CAFE || memory_read_valid !== 1'b1) begin bad++; $display("FAIL wrap_word0: got %h/%b want 0000cafe/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'hFFE, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        step();
        total++; if (memory_read_data !== 32'hCAFEF00D || memory_read_valid !== 1'b1) begin bad++; $display("FAIL wrap_split_rd: got %h/%b want cafef00d/1", memory_read_data, memory_read_valid); end
        issue(1'b1, 32'h1000, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'h0000CAFE) begin bad++; $display("FAIL wrap_alias: got %h want 0000cafe", memory_read_data); end
    endtask

    task automatic test_reset_rd_hi();
        issue(1'b1, 32'h17, 2'd2, 1'b0, 32'h0, 2'd0, 32'h0);
        rst = 1'b1;
        #1;
        total++; if (memory_busy !== 1'b0 || memory_read_data !== 32'h0) begin bad++; $display("FAIL rst_rdhi_clear: got busy=%b data=%h want 0/00000000", memory_busy, memory_read_data); end
        step();
        total++; if (memory_read_valid !== 1'b0) begin bad++; $display("FAIL rst_rdhi_novalid: got %b want 0", memory_read_valid); end
        rst = 1'b0;
        issue(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 2'd0, 32'h0);
        total++; if (memory_read_data !== 32'hAAADBEEF || memory_read_valid !== 1'b1) begin bad++; $display("FAIL rst_rdhi_after: got %h/%b want aaadbeef/1", memory_read_data, memory_read_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        rst                  = 1'b1;
        memory_read_enable   = 1'b0;
        memory_read_address  = '0;
        memory_read_width    = 2'd0;
        memory_write_enable  = 1'b0;
        memory_write_address = '0;
        memory_write_width   = 2'd0;
        memory_write_data    = '0;
        test_reset();
        test_word();
        test_byte_half();
        test_split();
        test_simultaneous();
        test_wrap();
        test_reset_rd_hi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
